// File: rtl/output_port_ctrl_pkg.sv
// Shared router definitions for the output-port controller: flit flag layout,
// default sizing and the wormhole lock state encoding.
package output_port_ctrl_pkg;

  localparam int unsigned DefDw    = 32;
  localparam int unsigned DefDepth = 4;

  // Position of the framing flags within a packed flag vector
  localparam int unsigned FlitHeadBit = 0;
  localparam int unsigned FlitTailBit = 1;
  localparam int unsigned FlitFlagW   = 2;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } port_state_e;

endpackage

// File: rtl/credit_cnt.sv
// Saturating up/down credit counter, reset to MAX, with an optional sticky
// overflow flag raised by a return while already full and not consuming.
module credit_cnt #(
  parameter int unsigned MAX   = 4,
  parameter bit          ChkEn = 1'b0,
  localparam int unsigned CW   = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          err
);

  logic [CW-1:0] count_d;
  logic          at_max;

  assign at_max = (count == CW'(MAX));

  always_comb begin
    count_d = count;
    if (inc && !dec && !at_max) count_d = count + CW'(1);
    else if (dec && !inc)       count_d = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count <= CW'(MAX);
    else     count <= count_d;
  end

  if (ChkEn) begin : g_chk
    logic err_q;
    always_ff @(posedge clk) begin
      if (rst)                          err_q <= 1'b0;
      else if (inc && !dec && at_max)   err_q <= 1'b1;
    end
    assign err = err_q;
  end else begin : g_nochk
    assign err = 1'b0;
  end

endmodule

// File: rtl/matrix_arbiter.sv
// Matrix arbiter: the winner drops to lowest priority when update is pulsed.
// Only the upper triangle of the priority matrix is stored.
module matrix_arbiter #(
  parameter int unsigned LEN = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [LEN-1:0] req,
  input  logic           update,
  output logic [LEN-1:0] grant
);

  localparam int unsigned NP = LEN * (LEN - 1) / 2;

  // Bit set: lower index of the pair beats the higher index
  logic [NP-1:0] prio_q, prio_d;

  function automatic int unsigned pidx(input int unsigned i, input int unsigned j);
    return i * LEN - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < LEN; i++) begin
      grant[i] = req[i];
      for (int unsigned j = 0; j < LEN; j++) begin
        if (j < i) begin
          if (req[j] && prio_q[pidx(j, i)]) grant[i] = 1'b0;
        end else if (j > i) begin
          if (req[j] && !prio_q[pidx(i, j)]) grant[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (update) begin
      for (int unsigned i = 0; i < LEN; i++) begin
        for (int unsigned j = i + 1; j < LEN; j++) begin
          if (grant[i]) prio_d[pidx(i, j)] = 1'b0;
          else if (grant[j]) prio_d[pidx(i, j)] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) prio_q <= '1;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/output_port_ctrl.sv
// Wormhole output-port controller: arbitrates head flits, locks to the winner
// until its tail, and forwards through a credit-gated registered slice.
// Optional credit overflow check: define OUTPUT_PORT_CTRL_CRED_CHK_EN.
module output_port_ctrl
  import output_port_ctrl_pkg::*;
#(
  parameter int unsigned LEN   = 3,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN-1:0]    in_valid,
  input  logic [LEN-1:0]    in_head,
  input  logic [LEN-1:0]    in_tail,
  input  logic [LEN*DW-1:0] in_data,
  output logic [LEN-1:0]    in_ready,
  output logic              out_valid,
  output logic              out_head,
  output logic              out_tail,
  output logic [DW-1:0]     out_data,
  input  logic              credit_in,
  output logic              cred_err
);

`ifdef OUTPUT_PORT_CTRL_CRED_CHK_EN
  localparam bit CredChk = 1'b1;
`else
  localparam bit CredChk = 1'b0;
`endif

  localparam int unsigned OwnerW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);

  port_state_e          state_q;
  logic [OwnerW-1:0]    owner_q;
  logic [CntW-1:0]      cred_cnt;
  logic                 has_cred;
  logic [LEN-1:0]       arb_req, arb_grant;
  logic                 arb_update;
  logic [OwnerW-1:0]    grant_idx;
  logic                 send;
  logic [DW-1:0]        sel_data;
  logic [FlitFlagW-1:0] sel_flags;

  assign has_cred = (cred_cnt != '0);
  assign arb_req  = (state_q == StIdle) ? (in_valid & in_head) : '0;

  matrix_arbiter #(
    .LEN (LEN)
  ) u_arb (
    .clk    (clk),
    .rstn   (~rst),
    .req    (arb_req),
    .update (arb_update),
    .grant  (arb_grant)
  );

  credit_cnt #(
    .MAX   (DEPTH),
    .ChkEn (CredChk)
  ) u_cred (
    .clk   (clk),
    .rst   (rst),
    .inc   (credit_in),
    .dec   (send),
    .count (cred_cnt),
    .err   (cred_err)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < LEN; i++) begin
      if (arb_grant[i]) grant_idx = OwnerW'(i);
    end
  end

  // A zero-credit grant leaves both ready and priority untouched
  always_comb begin
    in_ready   = '0;
    arb_update = 1'b0;
    if (!rst && has_cred) begin
      if (state_q == StIdle) begin
        in_ready   = arb_grant;
        arb_update = |arb_grant;
      end else begin
        for (int unsigned i = 0; i < LEN; i++) begin
          in_ready[i] = in_valid[i] && (owner_q == OwnerW'(i));
        end
      end
    end
  end

  assign send = |in_ready;

  always_comb begin
    sel_data  = '0;
    sel_flags = '0;
    for (int unsigned i = 0; i < LEN; i++) begin
      if (in_ready[i]) begin
        sel_data                = in_data[i*DW +: DW];
        sel_flags[FlitHeadBit]  = in_head[i];
        sel_flags[FlitTailBit]  = in_tail[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      out_valid <= 1'b0;
      out_head  <= 1'b0;
      out_tail  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= send;
      if (send) begin
        out_head <= sel_flags[FlitHeadBit];
        out_tail <= sel_flags[FlitTailBit];
        out_data <= sel_data;
      end
      case (state_q)
        StIdle: begin
          if (send && !sel_flags[FlitTailBit]) begin
            state_q <= StLocked;
            owner_q <= grant_idx;
          end
        end
        StLocked: begin
          if (send && sel_flags[FlitTailBit]) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_ctrl.sv
// Scoreboard bench for output_port_ctrl: directed vectors push expected flits,
// a monitor pops and compares them against out_* with cycle-accurate timing.
module tb_output_port_ctrl;

  localparam int unsigned LEN   = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

`ifdef OUTPUT_PORT_CTRL_CRED_CHK_EN
  localparam logic ExpErr = 1'b1;
`else
  localparam logic ExpErr = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [LEN-1:0]    in_valid = '0, in_head = '0, in_tail = '0;
  logic [LEN*DW-1:0] in_data = '0;
  logic [LEN-1:0]    in_ready;
  logic              out_valid, out_head, out_tail;
  logic [DW-1:0]     out_data;
  logic              credit_in = 1'b0;
  logic              cred_err;

  typedef struct {
    logic [DW+1:0] flit;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   ncyc = 0;

  output_port_ctrl #(
    .LEN   (LEN),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_head   (in_head),
    .in_tail   (in_tail),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_head  (out_head),
    .out_tail  (out_tail),
    .out_data  (out_data),
    .credit_in (credit_in),
    .cred_err  (cred_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; er is the hand-computed in_ready for this cycle
  task automatic step(input logic r, input logic [2:0] v, input logic [2:0] h,
                      input logic [2:0] t, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                      input logic cr, input logic [2:0] er, input string nm);
    logic [DW-1:0] d [3];
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_head   = h;
    in_tail   = t;
    in_data   = {d2, d1, d0};
    credit_in = cr;
    #1;
    chk(nm, 64'(in_ready), 64'(er));
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    for (int i = 0; i < 3; i++) begin
      if (er[i]) sb.push_back('{flit: {h[i], t[i], d[i]}, cyc: ncyc + 1});
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        nvec++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_flit: got %0h at cycle %0d, expected none",
                   {out_head, out_tail, out_data}, ncyc);
        end else begin
          e = sb.pop_front();
          if ({out_head, out_tail, out_data} !== e.flit || ncyc != e.cyc) begin
            nerr++;
            $display("FAIL out_flit: got %0h at cycle %0d, expected %0h at cycle %0d",
                     {out_head, out_tail, out_data}, ncyc, e.flit, e.cyc);
          end
        end
      end
    end
  end

  initial begin : stim
    // reset: ready forced low, outputs cleared
    step(1, 3'b111, 3'b111, 3'b111, 32'h1, 32'h2, 32'h3, 0, 3'b000, "rst_rdy");
    @(posedge clk); #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_flags", 64'({out_head, out_tail}), 64'(0));
    chk("rst_cred_err", 64'(cred_err), 64'(0));

    // single-flit packet
    step(0, 3'b010, 3'b010, 3'b010, 0, 32'hA5, 0, 0, 3'b010, "single");
    step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, "idle_cr");

    // wormhole lock: input 0 holds the port while input 2 waits
    step(0, 3'b101, 3'b101, 3'b100, 32'h10, 0, 32'h20, 1, 3'b001, "wh_head");
    step(0, 3'b101, 3'b100, 3'b100, 32'h11, 0, 32'h20, 1, 3'b001, "wh_body1");
    step(0, 3'b101, 3'b100, 3'b100, 32'h12, 0, 32'h20, 1, 3'b001, "wh_body2");
    step(0, 3'b101, 3'b100, 3'b101, 32'h13, 0, 32'h20, 1, 3'b001, "wh_tail");
    step(0, 3'b100, 3'b100, 3'b100, 0, 0, 32'h20, 1, 3'b100, "wh_next");

    // credit stall: 6-flit packet from input 1 with 4 credits
    step(0, 3'b010, 3'b010, 3'b000, 0, 32'h30, 0, 0, 3'b010, "st_0");
    step(0, 3'b010, 3'b000, 3'b000, 0, 32'h31, 0, 0, 3'b010, "st_1");
    step(0, 3'b010, 3'b000, 3'b000, 0, 32'h32, 0, 0, 3'b010, "st_2");
    step(0, 3'b010, 3'b000, 3'b000, 0, 32'h33, 0, 0, 3'b010, "st_3");
    step(0, 3'b010, 3'b000, 3'b000, 0, 32'h34, 0, 1, 3'b000, "st_stall");
    step(0, 3'b010, 3'b000, 3'b000, 0, 32'h34, 0, 0, 3'b010, "st_4");
    step(0, 3'b010, 3'b000, 3'b010, 0, 32'h35, 0, 1, 3'b000, "st_stall2");
    step(0, 3'b010, 3'b000, 3'b010, 0, 32'h35, 0, 0, 3'b010, "st_tail");

    // zero-credit grant must not rotate priority (0 still beats 2 below)
    step(0, 3'b101, 3'b101, 3'b101, 32'h41, 0, 32'h42, 0, 3'b000, "nocred_grant");
    step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, "cr_a");
    step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, "cr_b");
    // send with concurrent credit at count 2: count stays 2
    step(0, 3'b101, 3'b101, 3'b101, 32'h50, 0, 32'h51, 1, 3'b001, "simul");
    step(0, 3'b100, 3'b100, 3'b100, 0, 0, 32'h52, 0, 3'b100, "simul_n1");
    step(0, 3'b010, 3'b010, 3'b010, 0, 32'h53, 0, 0, 3'b010, "simul_n2");
    step(0, 3'b001, 3'b001, 3'b001, 32'h54, 0, 0, 0, 3'b000, "simul_empty");

    // refill to DEPTH, then one surplus credit
    for (int i = 0; i < 4; i++) step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, "refill");
    step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, "cr_over");
    @(posedge clk); #2;
    chk("cred_err_set", 64'(cred_err), 64'(ExpErr));

    // saturation: exactly DEPTH flits go out
    for (int i = 0; i < 4; i++) begin
      step(0, 3'b001, 3'b001, 3'b001, 32'h60 + i, 0, 0, 0, 3'b001, "sat_send");
    end
    step(0, 3'b001, 3'b001, 3'b001, 32'h64, 0, 0, 0, 3'b000, "sat_empty");
    chk("cred_err_sticky", 64'(cred_err), 64'(ExpErr));

    // reset mid-packet
    step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, "rm_cr_a");
    step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1, 3'b000, "rm_cr_b");
    step(0, 3'b100, 3'b100, 3'b000, 0, 0, 32'h70, 0, 3'b100, "rm_head");
    step(1, 3'b110, 3'b010, 3'b000, 0, 32'h80, 32'h71, 0, 3'b000, "rm_rst");
    @(posedge clk); #2;
    chk("rm_out_valid", 64'(out_valid), 64'(0));
    chk("rm_cred_err", 64'(cred_err), 64'(0));

    // rotation from reset priority; 4 sends prove credits were restored
    step(0, 3'b111, 3'b111, 3'b111, 32'h90, 32'h91, 32'h92, 0, 3'b001, "rot0");
    step(0, 3'b111, 3'b111, 3'b111, 32'h90, 32'h91, 32'h92, 0, 3'b010, "rot1");
    step(0, 3'b111, 3'b111, 3'b111, 32'h90, 32'h91, 32'h92, 0, 3'b100, "rot2");
    step(0, 3'b111, 3'b111, 3'b111, 32'h90, 32'h91, 32'h92, 0, 3'b001, "rot3");
    step(0, 3'b111, 3'b111, 3'b111, 32'h90, 32'h91, 32'h92, 1, 3'b000, "rot_stall");
    step(0, 3'b111, 3'b111, 3'b111, 32'h90, 32'h91, 32'h92, 1, 3'b010, "rot4");
    step(0, 3'b111, 3'b111, 3'b111, 32'h90, 32'h91, 32'h92, 1, 3'b100, "rot5");
    step(0, 3'b111, 3'b111, 3'b111, 32'h90, 32'h91, 32'h92, 1, 3'b001, "rot6");
    step(0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, "drain");

    repeat (3) @(posedge clk);
    #2;
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
